// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and hazard stall generation.
// Optional feature macro: ID_EX_FWD_EN (defined: forward from EX/MEM and MEM/WB; undefined: stall on RAW instead).
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [2:0]        id_alu_ctrl_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_res_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_res_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic              ex_valid_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              stall_req_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [2:0]        alu_ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_reg_t;

    ex_reg_t ex_q;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic load_use;
    logic ex_hit_rs1;
    logic ex_hit_rs2;

    // A bubble is the all-zero record, which also makes every derived output zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q <= '0;
        end else if (flush_i) begin
            ex_q <= '0;
        end else if (hold_i) begin
            ex_q <= ex_q;
        end else if (stall_req_o) begin
            ex_q <= '0;
        end else begin
            ex_q.valid     <= id_valid_i;
            ex_q.rs1       <= id_rs1_i;
            ex_q.rs2       <= id_rs2_i;
            ex_q.rd        <= id_rd_i;
            ex_q.rs1_data  <= id_rs1_data_i;
            ex_q.rs2_data  <= id_rs2_data_i;
            ex_q.imm       <= id_imm_i;
            ex_q.alu_ctrl  <= id_alu_ctrl_i;
            ex_q.alu_src   <= id_alu_src_i;
            ex_q.reg_write <= id_reg_write_i;
            ex_q.mem_read  <= id_mem_read_i;
            ex_q.mem_write <= id_mem_write_i;
        end
    end

    assign ex_hit_rs1 = (ex_q.rd == id_rs1_i);
    assign ex_hit_rs2 = id_use_rs2_i && (ex_q.rd == id_rs2_i);
    assign load_use   = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid_i
                        && (ex_hit_rs1 || ex_hit_rs2);

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
    always_comb begin
        rs1_val = ex_q.rs1_data;
        rs2_val = ex_q.rs2_data;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rs1)) begin
            rs1_val = exmem_res_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rs1)) begin
            rs1_val = memwb_res_i;
        end
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rs2)) begin
            rs2_val = exmem_res_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rs2)) begin
            rs2_val = memwb_res_i;
        end
    end

    assign stall_req_o = load_use;
`else
    logic raw_ex;
    logic raw_exmem;
    logic unused_fwd;

    assign rs1_val = ex_q.rs1_data;
    assign rs2_val = ex_q.rs2_data;

    // Without bypass paths any pending writer in EX or EX/MEM must drain first.
    assign raw_ex    = ex_q.valid && ex_q.reg_write && (ex_q.rd != '0) && id_valid_i
                       && (ex_hit_rs1 || ex_hit_rs2);
    assign raw_exmem = exmem_reg_write_i && (exmem_rd_i != '0) && id_valid_i
                       && ((exmem_rd_i == id_rs1_i) || (id_use_rs2_i && (exmem_rd_i == id_rs2_i)));

    assign stall_req_o = load_use || raw_ex || raw_exmem;
    assign unused_fwd  = ^{exmem_res_i, memwb_reg_write_i, memwb_rd_i, memwb_res_i,
                           ex_q.rs1, ex_q.rs2};
`endif

    assign alu_a_o        = rs1_val;
    assign store_data_o   = rs2_val;
    assign alu_b_o        = ex_q.alu_src ? ex_q.imm : rs2_val;
    assign alu_ctrl_o     = ex_q.alu_ctrl;
    assign ex_valid_o     = ex_q.valid;
    assign ex_rd_o        = ex_q.rd;
    assign ex_reg_write_o = ex_q.reg_write;
    assign ex_mem_read_o  = ex_q.mem_read;
    assign ex_mem_write_o = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the ID_EX_FWD_EN setting.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_use_rs2_i;
    logic [4:0]  id_rd_i;
    logic [31:0] id_rs1_data_i;
    logic [31:0] id_rs2_data_i;
    logic [31:0] id_imm_i;
    logic [2:0]  id_alu_ctrl_i;
    logic        id_alu_src_i;
    logic        id_reg_write_i;
    logic        id_mem_read_i;
    logic        id_mem_write_i;
    logic        hold_i;
    logic        flush_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_res_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_res_i;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] store_data_o;
    logic        ex_valid_o;
    logic [4:0]  ex_rd_o;
    logic        ex_reg_write_o;
    logic        ex_mem_read_o;
    logic        ex_mem_write_o;
    logic        stall_req_o;

    int compared = 0;
    int mismatched = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .hold_i(hold_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_res_i(exmem_res_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_res_i(memwb_res_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .ex_valid_o(ex_valid_o), .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .stall_req_o(stall_req_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, then let outputs settle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use_rs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [2:0] ctrl, input logic src, input logic rw,
                                 input logic mr, input logic mw);
        id_valid_i = valid; id_rs1_i = rs1; id_rs2_i = rs2; id_use_rs2_i = use_rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_alu_ctrl_i = ctrl;
        id_alu_src_i = src; id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
    endtask

    task automatic setDownstream(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                                 input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write_i = ew; exmem_rd_i = erd; exmem_res_i = eres;
        memwb_reg_write_i = mw; memwb_rd_i = mrd; memwb_res_i = mres;
    endtask

    initial begin
        rst_n_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        setDownstream(0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("reset_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("reset_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        checkOutput("reset_a", alu_a_o, 32'd0);
        checkOutput("reset_b", alu_b_o, 32'd0);
        checkOutput("reset_stall", {31'd0, stall_req_o}, 32'd0);
        rst_n_i = 1'b1;

        // ADD x7 = x3 + x4 enters EX
        tick();
        applyStimulus(1, 3, 4, 1, 7, 32'h111, 32'h222, 32'h5, 3'b010, 0, 1, 0, 0);
        #1 checkOutput("add_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        checkOutput("add_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("add_ctrl", {29'd0, alu_ctrl_o}, 32'd2);
        checkOutput("add_rd", {27'd0, ex_rd_o}, 32'd7);
        setDownstream(1, 3, 32'h10, 1, 3, 32'h20);
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_prio_exmem", alu_a_o, 32'h10);
`else
        checkOutput("fwd_prio_exmem", alu_a_o, 32'h111);
`endif
        checkOutput("fwd_b_plain", alu_b_o, 32'h222);
        setDownstream(1, 9, 32'h10, 1, 3, 32'h20);
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_prio_memwb", alu_a_o, 32'h20);
`else
        checkOutput("fwd_prio_memwb", alu_a_o, 32'h111);
`endif
        // asynchronous reset between edges
        rst_n_i = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("midreset_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        rst_n_i = 1'b1;

        // x0 source must never forward
        setDownstream(1, 0, 32'hFF, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 3'b001, 0, 1, 0, 0);
        tick();
        checkOutput("x0_a", alu_a_o, 32'd0);
        checkOutput("x0_b", alu_b_o, 32'd0);
        checkOutput("x0_ctrl", {29'd0, alu_ctrl_o}, 32'd1);

        // LW x5, 4(x1)
        setDownstream(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 5, 32'h100, 0, 32'h4, 3'b010, 1, 1, 1, 0);
        #1 checkOutput("lw_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        checkOutput("lw_memread", {31'd0, ex_mem_read_o}, 32'd1);
        checkOutput("lw_a", alu_a_o, 32'h100);
        checkOutput("lw_b", alu_b_o, 32'h4);
        // ADD x8 = x6 + x5 depends on the load
        applyStimulus(1, 6, 5, 1, 8, 32'h60, 32'hDEAD, 0, 3'b010, 0, 1, 0, 0);
        #1 checkOutput("lu_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        checkOutput("lu_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("lu_bubble_b", alu_b_o, 32'd0);
        setDownstream(1, 5, 32'h1234, 0, 0, 0);
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("lu_stall_once", {31'd0, stall_req_o}, 32'd0);
        tick();
        setDownstream(0, 0, 0, 1, 5, 32'hABCD);
        #1;
`else
        checkOutput("raw_exmem_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        checkOutput("raw_bubble2", {31'd0, ex_valid_o}, 32'd0);
        setDownstream(0, 0, 0, 1, 5, 32'hABCD);
        id_rs2_data_i = 32'hABCD;
        #1 checkOutput("raw_release", {31'd0, stall_req_o}, 32'd0);
        tick();
`endif
        checkOutput("lu_add_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("lu_add_a", alu_a_o, 32'h60);
        checkOutput("lu_add_b", alu_b_o, 32'hABCD);

        // store with immediate offset
        setDownstream(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 9, 1, 0, 0, 32'h99, 32'hFFFFFFFC, 3'b010, 1, 0, 0, 1);
        #1 checkOutput("st_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        setDownstream(0, 0, 0, 1, 9, 32'h777);
        #1;
        checkOutput("imm_b", alu_b_o, 32'hFFFFFFFC);
        checkOutput("imm_memwrite", {31'd0, ex_mem_write_o}, 32'd1);
`ifdef ID_EX_FWD_EN
        checkOutput("imm_store_data", store_data_o, 32'h777);
`else
        checkOutput("imm_store_data", store_data_o, 32'h99);
`endif

        // hold alone keeps contents for 3 cycles
        setDownstream(0, 0, 0, 0, 0, 0);
        hold_i = 1'b1;
        applyStimulus(1, 10, 0, 0, 11, 32'hAA, 0, 0, 3'b110, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_ctrl", {29'd0, alu_ctrl_o}, 32'd2);
            checkOutput("hold_b", alu_b_o, 32'hFFFFFFFC);
            checkOutput("hold_store", store_data_o, 32'h99);
        end
        hold_i = 1'b0;

        // LW x12, then dependent op: hold beats stall, flush beats both
        applyStimulus(1, 0, 0, 0, 12, 0, 0, 32'h8, 3'b010, 1, 1, 1, 0);
        tick();
        applyStimulus(1, 12, 0, 0, 13, 0, 0, 0, 3'b000, 0, 1, 0, 0);
        #1 checkOutput("prio_stall", {31'd0, stall_req_o}, 32'd1);
        hold_i = 1'b1;
        tick();
        checkOutput("hold_over_stall_mr", {31'd0, ex_mem_read_o}, 32'd1);
        checkOutput("hold_over_stall_rd", {27'd0, ex_rd_o}, 32'd12);
        flush_i = 1'b1;
        tick();
        checkOutput("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("flush_memread", {31'd0, ex_mem_read_o}, 32'd0);
        checkOutput("flush_rd", {27'd0, ex_rd_o}, 32'd0);
        checkOutput("flush_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        checkOutput("flush_b", alu_b_o, 32'd0);
        flush_i = 1'b0; hold_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection; sits directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle and drives the ALU's a/b operands and 3-bit control.
- Selects forwarded results from EX/MEM and MEM/WB.
- Requests a one-cycle stall on load-use hazards and inserts the bubble itself.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width; register 0 is hardwired zero

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
id_valid_i  input  1  ID holds a real instruction
id_rs1_i  input  REG_AW  source 1 address
id_rs2_i  input  REG_AW  source 2 address
id_use_rs2_i  input  1  instruction reads rs2 as a register (not imm-only)
id_rd_i  input  REG_AW  destination address
id_rs1_data_i  input  DATA_W  register file read 1
id_rs2_data_i  input  DATA_W  register file read 2
id_imm_i  input  DATA_W  sign-extended immediate
id_alu_ctrl_i  input  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 100 MUL
id_alu_src_i  input  1  1: b operand = imm
id_reg_write_i  input  1  writes rd
id_mem_read_i  input  1  load
id_mem_write_i  input  1  store
hold_i  input  1  downstream freeze; keep contents
flush_i  input  1  squash (branch taken); load bubble
exmem_reg_write_i  input  1  EX/MEM writes rd
exmem_rd_i  input  REG_AW  EX/MEM destination
exmem_res_i  input  DATA_W  EX/MEM ALU result
memwb_reg_write_i  input  1  MEM/WB writes rd
memwb_rd_i  input  REG_AW  MEM/WB destination
memwb_res_i  input  DATA_W  MEM/WB writeback value
alu_a_o  output  DATA_W  ALU operand a
alu_b_o  output  DATA_W  ALU operand b (imm or forwarded rs2)
alu_ctrl_o  output  3  ALU control
store_data_o  output  DATA_W  forwarded rs2 for stores
ex_valid_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  output  1/REG_AW/1/1/1  registered control to EX/MEM
stall_req_o  output  1  combinational; upstream must freeze PC and IF/ID this cycle

Behaviour:
- Reset: all registered fields 0, so ex_valid_o=0, alu_ctrl_o=000 (AND), alu_a_o=alu_b_o=0, stall_req_o=0. Reset is asynchronous and may assert mid-operation; contents clear immediately.
- Register update priority per edge: flush_i > hold_i > stall_req_o > normal load.
  - flush: load bubble.
  - hold: keep all contents.
  - stall_req_o: load bubble.
  - normal: capture all id_* fields; valid = id_valid_i.
- Bubble: valid, reg_write, mem_read and mem_write = 0; data and ctrl fields 0.
- Hazard: stall_req_o = ex_valid & ex_mem_read & ex_rd != 0 & id_valid_i & (ex_rd == id_rs1 | (id_use_rs2 & ex_rd == id_rs2)). Result is 1 cycle of stall per load-use.
- Forwarding (combinational on registered rs1/rs2):
  - Forward from EX/MEM if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs. Else from MEM/WB under the same rule. Else use the registered register-file data.
  - EX/MEM has priority when both match.
  - rs == 0 never forwards.
- Operand selection:
  - alu_a_o = fwd(rs1).
  - store_data_o = fwd(rs2).
  - alu_b_o = imm if alu_src, else fwd(rs2).
  - Bubble outputs are 0.
- Latency: 1 cycle ID to EX; forwarding adds 0 cycles.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding as above; stall_req_o only on load-use.
- Undefined: no forward muxes; operands are the registered register-file data. stall_req_o also asserts when id rs1, or rs2 with use_rs2, equals a nonzero rd of either:
  - the EX stage, when valid & reg_write;
  - the EX/MEM stage, when exmem_reg_write.
- Bubbles are inserted each stalled cycle, giving up to 2 stall cycles per RAW.

Test Plan:
- Reset: rst_n_i=0 mid-stream with ex_valid=1 -> ex_valid_o=0 and alu_ctrl_o=000 immediately, without waiting for a clock edge.
- Forward priority: EX rs1=3; exmem rd=3 res=0x10 and memwb rd=3 res=0x20 -> alu_a_o=0x10. Drop the exmem match -> alu_a_o=0x20.
- x0: rs1=0 and exmem rd=0 with reg_write=1, res=0xFF -> alu_a_o = registered value 0.
- Load-use: EX lw rd=5; ID add rs2=5, use_rs2=1 -> stall_req_o=1 for exactly 1 cycle. Next EX is a bubble (ex_valid_o=0), then the add enters with b forwarded from memwb.
- Priority: flush_i=1 with hold_i=1 and stall_req_o=1 -> bubble loaded. hold_i alone -> outputs unchanged over 3 cycles.
- Immediate: alu_src=1, imm=0xFFFFFFFC, ctrl=010 -> alu_b_o=0xFFFFFFFC, and store_data_o still equals fwd(rs2).
